mips_prog_loader: RTL

- Byte-stream program loader upstream of the pipelined MIPS32 core.
- Receives a framed image (sync, load address, word count, big-endian 32-bit words, optional checksum) and writes each word into the core's Mem[] through a single write port.
- On completion it sets the core's start PC and pulses start.
- Holds the core halted (cpu_hold) for the whole load, so no program is ever poked in by hand.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mips_prog_loader_word_asm.sv | 37 +++
 rtl/mips_prog_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 program loader.
package mips_pkg;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CNT_W     = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    DATA,
    CSUM,
    START,
    ERR
  } ld_state_t;

  // True for states whose accepted bytes belong to the checksummed body of a frame.
  function automatic logic in_frame_body(input ld_state_t s);
    return (s == ADDR_HI) || (s == ADDR_LO) || (s == CNT_HI) ||
           (s == CNT_LO)  || (s == DATA);
  endfunction

endpackage

// File: rtl/mips_prog_loader_word_asm.sv
// Assembles four stream bytes MSB-first into one 32-bit word.
// word_c / word_done_c are combinational: they present the completed word
// in the same cycle its 4th byte is accepted, so the parent can register it.
module ld_word_asm
  import mips_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              din_valid,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word_c,
  output logic              word_done_c
);

  localparam int unsigned SH_W = WORD_W - BYTE_W;

  logic [SH_W-1:0] sh;
  logic [1:0]      bcnt;

  assign word_c      = {sh, din};
  assign word_done_c = din_valid && (bcnt == 2'd3);

  // Shift register and byte position; bcnt wraps 3->0 on word completion.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      sh   <= '0;
      bcnt <= '0;
    end else if (clr) begin
      bcnt <= '0;
    end else if (din_valid) begin
      sh   <= {sh[SH_W-BYTE_W-1:0], din};
      bcnt <= bcnt + 2'd1;
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Byte-stream program loader for the pipelined MIPS32 core.
// Frame: SYNC, addr[15:8], addr[7:0], cnt[15:8], cnt[7:0], cnt x 4 data bytes
// (big-endian words), then an XOR checksum byte when LOADER_CHECKSUM_EN is
// defined. Without that macro there is no checksum and err is tied low.
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W    = $clog2(MEM_WORDS),
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] cpu_pc,
  output logic              cpu_start,
  output logic              cpu_hold,
  output logic              busy,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t POST_ST = CSUM;
`else
  localparam ld_state_t POST_ST = START;
`endif

  ld_state_t         state;
  ld_state_t         nxt;
  logic              acc;
  logic              data_acc;
  logic              asm_clr;
  logic [BYTE_W-1:0] addr_hi;
  logic [BYTE_W-1:0] cnt_hi;
  logic [CNT_W-1:0]  cnt_full;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [WORD_W-1:0] word_c;
  logic              word_done_c;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  assign acc      = in_valid && in_ready;
  assign data_acc = acc && (state == DATA);
  assign asm_clr  = (state != DATA);
  assign cnt_full = {cnt_hi, in_data};

  ld_word_asm u_word_asm (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .clr         (asm_clr),
    .din_valid   (data_acc),
    .din         (in_data),
    .word_c      (word_c),
    .word_done_c (word_done_c)
  );

  // Next-state decode; only accepted bytes (or START's fixed cycle) advance.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc && (in_data == SYNC_BYTE)) nxt = ADDR_HI;
      ADDR_HI: if (acc) nxt = ADDR_LO;
      ADDR_LO: if (acc) nxt = CNT_HI;
      CNT_HI:  if (acc) nxt = CNT_LO;
      CNT_LO:  if (acc) nxt = (cnt_full == '0) ? POST_ST : DATA;
      DATA:    if (word_done_c && (remaining == CNT_W'(1))) nxt = POST_ST;
      CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (acc) nxt = (in_data == csum) ? START : ERR;
`else
        nxt = IDLE;
`endif
      end
      START:   nxt = IDLE;
      ERR:     if (acc && (in_data == SYNC_BYTE)) nxt = ADDR_HI;
      default: nxt = IDLE;
    endcase
  end

  // State, frame registers and all registered outputs.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_hi   <= '0;
      cnt_hi    <= '0;
      remaining <= '0;
      load_addr <= '0;
      cur_addr  <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_pc    <= '0;
      cpu_start <= 1'b0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= nxt;
      in_ready  <= (nxt != START);
      mem_we    <= word_done_c;
      cpu_start <= (nxt == START);
      busy      <= !((nxt == IDLE) || (nxt == ERR));
`ifdef LOADER_CHECKSUM_EN
      err       <= (nxt == ERR);
`else
      err       <= 1'b0;
`endif

      if (nxt == START) begin
        cpu_pc   <= load_addr;
        cpu_hold <= 1'b0;
      end else if ((nxt == ADDR_HI) && (state != ADDR_HI)) begin
        cpu_hold <= 1'b1;
      end

      if (acc) begin
        case (state)
          ADDR_HI: addr_hi <= in_data;
          ADDR_LO: begin
            load_addr <= ADDR_W'({addr_hi, in_data});
            cur_addr  <= ADDR_W'({addr_hi, in_data});
          end
          CNT_HI:  cnt_hi    <= in_data;
          CNT_LO:  remaining <= cnt_full;
          default: ;
        endcase
      end

      if (word_done_c) begin
        mem_addr  <= cur_addr;
        mem_wdata <= word_c;
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // XOR over every byte after sync; cleared when a new frame's sync is taken.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (acc) begin
      if ((state == IDLE) || (state == ERR)) begin
        if (in_data == SYNC_BYTE) csum <= '0;
      end else if (in_frame_body(state)) begin
        csum <= csum ^ in_data;
      end
    end
  end
`endif

endmodule
